// File: rtl/cp0_exception_unit.sv
// CP0 coprocessor: SR/Cause/EPC/PRId registers, interrupt and exception request logic.
// Define CP0_BADVADDR_EN to add the BadVAddr register (reg 8).
module cp0_exception_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  A1,
   input  logic [4:0]  A2,
   input  logic [31:0] DIn,
   input  logic        WE,
   input  logic [31:0] VPC,
   input  logic        BDIn,
   input  logic [4:0]  ExcCodeIn,
   input  logic [31:0] BadAddrIn,
   input  logic [5:0]  HWInt,
   input  logic        EXLClr,
   output logic        Req,
   output logic [31:0] EPCOut,
   output logic [31:0] DOut
);

   localparam logic [31:0] PRID = 32'h0000_4D50;

   logic [5:0]  sr_im_q, sr_im_d;
   logic        sr_exl_q, sr_exl_d;
   logic        sr_ie_q, sr_ie_d;
   logic        cause_bd_q, cause_bd_d;
   logic [5:0]  cause_ip_q, cause_ip_d;
   logic [4:0]  cause_exc_q, cause_exc_d;
   logic [31:0] epc_q, epc_d;
   logic [31:0] badvaddr_rd;

   logic        int_req;
   logic        exc_req;
   logic [31:0] epc_exc;
   logic [31:0] sr_word;
   logic [31:0] cause_word;

   assign int_req = (|(HWInt & sr_im_q)) & sr_ie_q & ~sr_exl_q;
   assign exc_req = (ExcCodeIn != 5'd0) & ~sr_exl_q;
   assign Req     = int_req | exc_req;

   // A delay-slot victim restarts at its branch so the branch re-executes.
   assign epc_exc = (BDIn ? (VPC - 32'd4) : VPC) & ~32'h3;

   assign sr_word    = {16'h0, sr_im_q, 8'h0, sr_exl_q, sr_ie_q};
   assign cause_word = {cause_bd_q, 15'h0, cause_ip_q, 3'h0, cause_exc_q, 2'h0};

   always_comb begin
      sr_im_d     = sr_im_q;
      sr_exl_d    = sr_exl_q;
      sr_ie_d     = sr_ie_q;
      cause_bd_d  = cause_bd_q;
      cause_ip_d  = HWInt;
      cause_exc_d = cause_exc_q;
      epc_d       = epc_q;
      if (Req) begin
         sr_exl_d    = 1'b1;
         cause_exc_d = int_req ? 5'd0 : ExcCodeIn;
         cause_bd_d  = BDIn;
         epc_d       = epc_exc;
      end else begin
         if (WE && (A2 == 5'd12)) begin
            sr_im_d  = DIn[15:10];
            sr_exl_d = DIn[1];
            sr_ie_d  = DIn[0];
         end
         if (WE && (A2 == 5'd14)) epc_d = DIn;
         if (EXLClr) sr_exl_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sr_im_q     <= 6'h0;
         sr_exl_q    <= 1'b0;
         sr_ie_q     <= 1'b0;
         cause_bd_q  <= 1'b0;
         cause_ip_q  <= 6'h0;
         cause_exc_q <= 5'h0;
         epc_q       <= 32'h0;
      end else begin
         sr_im_q     <= sr_im_d;
         sr_exl_q    <= sr_exl_d;
         sr_ie_q     <= sr_ie_d;
         cause_bd_q  <= cause_bd_d;
         cause_ip_q  <= cause_ip_d;
         cause_exc_q <= cause_exc_d;
         epc_q       <= epc_d;
      end
   end

`ifdef CP0_BADVADDR_EN
   logic [31:0] badvaddr_q, badvaddr_d;

   always_comb begin
      badvaddr_d = badvaddr_q;
      if (Req && exc_req && !int_req && ((ExcCodeIn == 5'd4) || (ExcCodeIn == 5'd5)))
         badvaddr_d = BadAddrIn;
   end

   always_ff @(posedge clk) begin
      if (reset) badvaddr_q <= 32'h0;
      else       badvaddr_q <= badvaddr_d;
   end

   assign badvaddr_rd = badvaddr_q;
`else
   logic unused_badaddr;
   assign unused_badaddr = ^BadAddrIn;
   assign badvaddr_rd    = 32'h0;
`endif

   assign EPCOut = epc_q;

   always_comb begin
      DOut = 32'h0;
      case (A1)
         5'd8:    DOut = badvaddr_rd;
         5'd12:   DOut = sr_word;
         5'd13:   DOut = cause_word;
         5'd14:   DOut = epc_q;
         5'd15:   DOut = PRID;
         default: DOut = 32'h0;
      endcase
   end

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Directed self-checking bench for cp0_exception_unit with an expected-value queue.
module tb_cp0_exception_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  A1, A2;
   logic [31:0] DIn;
   logic        WE;
   logic [31:0] VPC;
   logic        BDIn;
   logic [4:0]  ExcCodeIn;
   logic [31:0] BadAddrIn;
   logic [5:0]  HWInt;
   logic        EXLClr;
   logic        Req;
   logic [31:0] EPCOut;
   logic [31:0] DOut;

   int checks   = 0;
   int failures = 0;
   logic [31:0] exp_q[$];

`ifdef CP0_BADVADDR_EN
   localparam logic [31:0] BADV_EXP = 32'h0000_7f09;
`else
   localparam logic [31:0] BADV_EXP = 32'h0;
`endif

   cp0_exception_unit dut (
      .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE),
      .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .BadAddrIn(BadAddrIn),
      .HWInt(HWInt), .EXLClr(EXLClr), .Req(Req), .EPCOut(EPCOut), .DOut(DOut)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] v);
      exp_q.push_back(v);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $error("FAIL %s observed=%h expected=<queue empty>", tag, obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
         end
      end
   endtask

   task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] e);
      A1 = a;
      push(e);
      #1;
      chk(tag, DOut);
   endtask

   task automatic req_is(input string tag, input logic e);
      push({31'h0, e});
      #1;
      chk(tag, {31'h0, Req});
   endtask

   task automatic idle();
      WE = 1'b0; A2 = 5'd0; DIn = 32'h0; ExcCodeIn = 5'd0; BDIn = 1'b0;
      EXLClr = 1'b0; BadAddrIn = 32'h0;
   endtask

   task automatic eret();
      EXLClr = 1'b1;
      tick();
      EXLClr = 1'b0;
   endtask

   initial begin
      reset = 1'b1; A1 = 5'd0; HWInt = 6'h0; VPC = 32'h0;
      idle();
      tick(); tick();
      reset = 1'b0;
      req_is("reset_req", 1'b0);
      push(32'h0); chk("reset_epcout", EPCOut);
      rd(5'd12, "reset_sr", 32'h0);
      rd(5'd13, "reset_cause", 32'h0);
      rd(5'd14, "reset_epc", 32'h0);
      rd(5'd15, "prid", 32'h0000_4D50);
      rd(5'd8,  "reset_badv", 32'h0);
      rd(5'd3,  "unmapped_reg", 32'h0);

      // Overflow exception, same-cycle request then registered results
      ExcCodeIn = 5'd12; VPC = 32'h3010;
      req_is("ov_req", 1'b1);
      tick(); idle();
      rd(5'd13, "ov_cause", 32'h0000_0030);
      push(32'h3010); chk("ov_epcout", EPCOut);
      rd(5'd12, "ov_sr_exl", 32'h0000_0002);
      req_is("ov_req_masked", 1'b0);
      eret();
      rd(5'd12, "eret_sr", 32'h0);

      // Interrupt enable and interrupt priority
      WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401;
      tick(); idle();
      rd(5'd12, "mtc0_sr", 32'h0000_0401);
      HWInt = 6'b000001;
      req_is("int_req", 1'b1);
      tick(); HWInt = 6'h0;
      rd(5'd13, "int_cause", 32'h0000_0400);
      rd(5'd12, "int_sr", 32'h0000_0403);
      eret();
      HWInt = 6'b000001; ExcCodeIn = 5'd8;
      req_is("int_sys_req", 1'b1);
      tick(); idle(); HWInt = 6'h0;
      rd(5'd13, "int_wins_cause", 32'h0000_0400);
      eret();

      // Delay-slot reserved instruction
      ExcCodeIn = 5'd10; BDIn = 1'b1; VPC = 32'h3024;
      tick(); idle();
      push(32'h3020); chk("bd_epcout", EPCOut);
      rd(5'd13, "bd_cause", 32'h8000_0028);
      eret();
      rd(5'd12, "bd_eret_sr", 32'h0000_0401);

      // mtc0 EPC coincident with AdES is dropped
      WE = 1'b1; A2 = 5'd14; DIn = 32'h4000; ExcCodeIn = 5'd5; VPC = 32'h3040;
      BadAddrIn = 32'h7f09;
      tick(); idle();
      push(32'h3040); chk("ades_epc_not_written", EPCOut);
      rd(5'd13, "ades_cause", 32'h0000_0014);
      rd(5'd8,  "ades_badvaddr", BADV_EXP);
      eret();

      // Plain mtc0 EPC; DOut shows the pre-edge value during the write
      WE = 1'b1; A2 = 5'd14; DIn = 32'h4000;
      rd(5'd14, "epc_no_write_through", 32'h3040);
      tick(); idle();
      push(32'h4000); chk("mtc0_epc", EPCOut);
      WE = 1'b1; A2 = 5'd13; DIn = 32'hffff_ffff;
      tick(); idle();
      rd(5'd13, "cause_read_only", 32'h0000_0014);
      rd(5'd12, "sr_unchanged", 32'h0000_0401);

      // Nested request suppressed while EXL set
      ExcCodeIn = 5'd12; VPC = 32'h3050;
      tick(); idle();
      WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_fc03;
      tick(); idle();
      rd(5'd12, "exl_sr_im", 32'h0000_fc03);
      ExcCodeIn = 5'd4; HWInt = 6'h3f; VPC = 32'h3060; BadAddrIn = 32'h1234;
      req_is("exl_blocks_req", 1'b0);
      tick(); idle();
      push(32'h3050); chk("exl_epc_hold", EPCOut);
      rd(5'd13, "exl_cause_ip", 32'h0000_fc30);
      rd(5'd8,  "exl_badv_hold", BADV_EXP);
      HWInt = 6'h0;
      eret();

      // Req beats EXLClr in the same cycle
      ExcCodeIn = 5'd12; EXLClr = 1'b1;
      tick(); idle();
      rd(5'd12, "req_over_eret", 32'h0000_fc03);
      eret();

      // Reset overrides a pending request
      ExcCodeIn = 5'd8; VPC = 32'h3070; reset = 1'b1;
      req_is("pre_reset_req", 1'b1);
      tick(); idle(); reset = 1'b0;
      rd(5'd12, "rst_sr", 32'h0);
      rd(5'd13, "rst_cause", 32'h0);
      rd(5'd8,  "rst_badv", 32'h0);
      push(32'h0); chk("rst_epcout", EPCOut);
      req_is("rst_req", 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
